// File: rtl/fir_ber_pkg.sv
// fir_ber_pkg: shared FSM states, slicer thresholds and slicer function
package fir_ber_pkg;
   typedef enum logic [1:0] {IDLE, FILL, COUNT, REPORT} state_t;
   localparam logic [3:0] TH0 = 4'd4;
   localparam logic [3:0] TH1 = 4'd8;
   localparam logic [3:0] TH2 = 4'd12;
   function automatic logic [1:0] slice(input logic [3:0] y);
      return {1'b0, y >= TH0} + {1'b0, y >= TH1} + {1'b0, y >= TH2};
   endfunction
endpackage

// File: rtl/fir_ref_delay.sv
// fir_ref_delay: reference symbol delay line; tap 0 is the live input, tap k is k en-samples old
module fir_ref_delay #(
   parameter int DLY_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       x_ref,
   input  logic [DLY_W-1:0] sel,
   output logic [1:0]       tap
);
   localparam int D = 2 ** DLY_W;
   logic [2*D-1:2] sr;
   logic [2*D-1:0] line;
   always_ff @(posedge clk or negedge rst)
      if (!rst) sr <= '0;
      else if (en) sr <= {sr[2*D-3:2], x_ref};
   assign line = {sr, x_ref};
   assign tap = line[{sel, 1'b0} +: 2];
endmodule

// File: rtl/fir_ber_checker.sv
// fir_ber_checker: slices FIR output, compares to delayed reference, counts errors per window.
// Optional FIR_BER_FIRST_ERR_EN adds first_err (1-based index of first error in last window).
module fir_ber_checker import fir_ber_pkg::*; #(
   parameter int DLY_W = 3,
   parameter int WIN_W = 8,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             cont,
   input  logic [DLY_W-1:0] dly,
   input  logic [1:0]       x_ref,
   input  logic [3:0]       y_in,
   output logic [1:0]       dec,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_cnt
`ifdef FIR_BER_FIRST_ERR_EN
   ,
   output logic [WIN_W:0]   first_err
`endif
);
   state_t state, nxt;
   logic [DLY_W-1:0] dly_q, fill_cnt;
   logic [WIN_W:0] sym_cnt, sym_inc;
   logic [ERR_W-1:0] acc, acc_nxt;
   logic [1:0] tap, d;
   logic err, last, cnt_en;
   fir_ref_delay #(.DLY_W(DLY_W)) u_dly (.clk, .rst, .en, .x_ref, .sel(dly_q), .tap);
   assign d = slice(y_in);
   assign err = d != tap;
   assign cnt_en = state == COUNT && en;
   assign sym_inc = sym_cnt + (WIN_W+1)'(1);
   assign last = cnt_en && sym_inc == (WIN_W+1)'(2 ** WIN_W);
   assign acc_nxt = acc + ERR_W'(err && !(&acc));
   assign busy = state == FILL || state == COUNT;
   assign done = state == REPORT;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? ((en && dly == '0) ? COUNT : FILL) : IDLE;
         FILL:    nxt = (en && fill_cnt == dly_q) ? COUNT : FILL;
         COUNT:   nxt = last ? REPORT : COUNT;
         REPORT:  nxt = cont ? COUNT : IDLE;
         default: nxt = IDLE;
      endcase
   end
   // result is loaded on the edge entering REPORT so it is valid alongside done
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         dly_q    <= '0;
         fill_cnt <= '0;
         sym_cnt  <= '0;
         acc      <= '0;
         dec      <= '0;
         err_cnt  <= '0;
      end else begin
         state <= nxt;
         if (en) dec <= d;
         if (state == IDLE && start) begin
            dly_q    <= dly;
            fill_cnt <= DLY_W'(en);
         end
         if (state == FILL && en) fill_cnt <= fill_cnt + DLY_W'(1);
         if (cnt_en) begin
            sym_cnt <= last ? '0 : sym_inc;
            acc     <= last ? '0 : acc_nxt;
         end
         if (last) err_cnt <= acc_nxt;
      end
`ifdef FIR_BER_FIRST_ERR_EN
   logic [WIN_W:0] first_q, first_nxt;
   assign first_nxt = (first_q == '0 && err) ? sym_inc : first_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         first_q   <= '0;
         first_err <= '0;
      end else if (cnt_en) begin
         first_q <= last ? '0 : first_nxt;
         if (last) first_err <= first_nxt;
      end
`endif
endmodule

// File: tb/tb_fir_ber_checker.sv
// tb_fir_ber_checker: directed stimulus with an abstract per-sample model and literal spot checks
module tb_fir_ber_checker;
   logic clk = 0, rst = 0, en = 0, start = 0, cont = 0;
   logic [2:0] dly = 0;
   logic [1:0] x_ref = 0;
   logic [3:0] y_in = 0;
   logic [1:0] dec;
   logic busy, done;
   logic [7:0] err_cnt;
`ifdef FIR_BER_FIRST_ERR_EN
   logic [8:0] first_err;
`endif
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;

   fir_ber_checker dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont), .dly(dly),
      .x_ref(x_ref), .y_in(y_in), .dec(dec), .busy(busy), .done(done), .err_cnt(err_cnt)
`ifdef FIR_BER_FIRST_ERR_EN
      , .first_err(first_err)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // model: phase 0 idle, 1 fill, 2 count, 3 report; decisions are y/4
   int ph, need, n, errs, first, m_dly, m_r, e_err, e_first, e_dec;
   int hist[$];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph = 0; need = 0; n = 0; errs = 0; first = 0; m_dly = 0;
         e_err = 0; e_first = 0; e_dec = 0;
         hist.delete();
         repeat (8) hist.push_back(0);
      end else begin
         if (en) begin
            hist.push_front(int'(x_ref));
            void'(hist.pop_back());
            e_dec = int'(y_in) / 4;
         end
         m_r = hist[m_dly];
         case (ph)
            0: if (start) begin
                  m_dly = int'(dly);
                  need = m_dly + 1 - int'(en);
                  ph = (need == 0) ? 2 : 1;
               end
            1: if (en) begin
                  need--;
                  if (need == 0) ph = 2;
               end
            2: if (en) begin
                  n++;
                  if (int'(y_in) / 4 != m_r) begin
                     if (errs < 255) errs++;
                     if (first == 0) first = n;
                  end
                  if (n == 256) begin
                     e_err = errs; e_first = first;
                     n = 0; errs = 0; first = 0; ph = 3;
                  end
               end
            default: ph = cont ? 2 : 0;
         endcase
      end
   end

   always @(negedge clk) if (rst) begin
      chk("dec", dec, e_dec);
      chk("busy", busy, ph == 1 || ph == 2);
      chk("done", done, ph == 3);
      chk("err_cnt", err_cnt, e_err);
`ifdef FIR_BER_FIRST_ERR_EN
      chk("first_err", first_err, e_first);
`endif
   end

   // stand-in FIR: y = 4*x three samples back + 1; mode 1 forces a wrong symbol, mode 3 drives yv
   int fh[8];
   int mode = 0;
   logic [3:0] yv = 0;
   task automatic cyc(input bit e, input bit s);
      x_ref = 2'($urandom_range(0, 3));
      y_in = (mode == 3) ? yv : (mode == 1) ? 4'(4 * ((fh[2] + 1) % 4) + 1) : 4'(4 * fh[2] + 1);
      en = e;
      start = s;
      @(posedge clk);
      #1;
      if (e) begin
         for (int k = 7; k > 0; k--) fh[k] = fh[k-1];
         fh[0] = int'(x_ref);
      end
      start = 0;
   endtask

   task automatic wait_done(input int period, output int c);
      c = 0;
      while (c < 3000 && !done) begin
         cyc(c % period == 0, 1'b0);
         c++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_dec"}, dec, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err_cnt, 0);
`ifdef FIR_BER_FIRST_ERR_EN
      chk({tag, "_first"}, first_err, 0);
`endif
   endtask

   logic [1:0] tbl [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
   int c, nd, d1, d2;
   initial begin
      foreach (fh[k]) fh[k] = 0;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("rst0");
      rst = 1;
      mode = 3;
      for (int v = 0; v < 16; v++) begin
         yv = 4'(v);
         cyc(1, 0);
         chk("slice", dec, tbl[v]);
      end
      mode = 0;
      repeat (5) cyc(1, 0);
      dly = 3;
      cyc(1, 1);
      dly = 5;
      wait_done(1, c);
      chk("ideal_lat", c, 259);
      chk("ideal_err", err_cnt, 0);
`ifdef FIR_BER_FIRST_ERR_EN
      chk("ideal_first", first_err, 0);
`endif
      cyc(1, 0);
      dly = 2;
      cyc(1, 1);
      wait_done(1, c);
      chk("misalign_range", err_cnt >= 162 && err_cnt <= 222, 1);
      cyc(1, 0);
      mode = 1;
      dly = 3;
      cyc(1, 1);
      wait_done(1, c);
      chk("sat_err", err_cnt, 255);
`ifdef FIR_BER_FIRST_ERR_EN
      chk("sat_first", first_err, 1);
`endif
      cyc(0, 0);
      mode = 0;
      cyc(1, 1);
      repeat (3) cyc(1, 0);
      mode = 1;
      repeat (5) cyc(1, 0);
      mode = 0;
      repeat (4) cyc(1, 1);
      chk("mid_busy", busy, 1);
      rst = 0;
      #1;
      reset_checks("rst1");
      foreach (fh[k]) fh[k] = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
      dly = 3;
      cyc(1, 1);
      wait_done(1, c);
      chk("fresh_lat", c, 259);
      chk("fresh_err", err_cnt, 0);
      cyc(0, 0);
      cont = 1;
      dly = 1;
      cyc(1, 1);
      nd = 0; d1 = 0; d2 = 0;
      for (int i = 1; i < 1600; i++) begin
         cyc(i % 3 == 0, i % 50 == 25);
         if (done) begin
            nd++;
            if (nd == 1) d1 = i; else d2 = i;
         end
      end
      chk("cont_dones", nd, 2);
      chk("cont_first", d1, 771);
      chk("cont_gap", d2 - d1, 768);
      cont = 0;
      wait_done(3, c);
      cyc(0, 0);
      chk("end_busy", busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
